muldiv_sequencer: RTL and testbench

- Multi-cycle signed multiply/divide unit with its controller, for the MIPS single-cycle core; owns the HI/LO registers.
- Sequences the iterative mult, div and mul operations selected by the ALU_control codes.
- Raises a stall to the core while busy whenever a new muldiv op or an mfhi/mflo needs HI/LO.

---
 rtl/muldiv_sequencer_pkg.sv | 24 ++
 rtl/muldiv_sequencer_datapath.sv | 101 ++++++++++
 rtl/muldiv_sequencer.sv | 131 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU op codes, FSM state encoding and op decode for the multiply/divide unit.
package muldiv_sequencer_pkg;

  localparam logic [3:0] ALU_MULT = 4'b1101;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_MFHI = 4'b1110;
  localparam logic [3:0] ALU_MFLO = 4'b0111;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;
  typedef enum logic [1:0] {OP_MULT, OP_DIV, OP_MUL, OP_NONE} op_e;

  function automatic op_e decode_op(input logic [3:0] code);
    op_e op;
    case (code)
      ALU_MULT: op = OP_MULT;
      ALU_DIV:  op = OP_DIV;
      ALU_MUL:  op = OP_MUL;
      default:  op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Magnitude registers, shift-add / restoring-divide iteration and sign fixup.
// Operates on magnitudes; signs are applied combinationally on the outputs.
module muldiv_sequencer_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  op_e                op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               div_zero,
  output logic               mplier_zero,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d, d_q, d_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, is_div_q, is_div_d;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     shifted, trial;

  assign div_zero    = (rt_val == '0);
  assign mplier_zero = ~|b_q[WIDTH-1:1];

  always_comb begin
    mag_a    = rs_val[WIDTH-1] ? -rs_val : rs_val;
    mag_b    = rt_val[WIDTH-1] ? -rt_val : rt_val;
    shifted  = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
    trial    = shifted - {1'b0, d_q};
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    if (load) begin
      is_div_d = (op == OP_DIV);
      neg_d    = rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
      rneg_d   = rs_val[WIDTH-1];
      a_d      = {{WIDTH{1'b0}}, mag_a};
      b_d      = mag_b;
      d_d      = mag_b;
      acc_d    = '0;
      if (op == OP_DIV) begin
        b_d = mag_a;
        // Divide by zero: remainder holds the dividend, quotient is all ones.
        if (div_zero) begin
          acc_d = {{WIDTH{1'b0}}, mag_a};
          b_d   = '1;
          neg_d = 1'b0;
        end
      end
    end else if (step) begin
      if (is_div_q) begin
        if (!trial[WIDTH]) begin
          acc_d = {{(WIDTH-1){1'b0}}, trial};
          b_d   = {b_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {{(WIDTH-1){1'b0}}, shifted};
          b_d   = {b_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
    end
  end

  assign prod = neg_q  ? -acc_q : acc_q;
  assign quot = neg_q  ? -b_q   : b_q;
  assign rem  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed mult/div/mul controller owning HI/LO.
// Define MULDIV_EARLY_TERM_EN to end mult/mul as soon as the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mul_result,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d, op_in;
  logic [CW-1:0]      counter_q, counter_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mul_q, mul_d;
  logic               load, step, div_zero, mplier_zero, calc_exit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign op_in = decode_op(alu_ctrl);

  muldiv_sequencer_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .op         (op_in),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .div_zero   (div_zero),
    .mplier_zero(mplier_zero),
    .prod       (prod),
    .quot       (quot),
    .rem        (rem)
  );

`ifdef MULDIV_EARLY_TERM_EN
  assign calc_exit = (counter_q == CW'(1)) || ((op_q != OP_DIV) && mplier_zero);
`else
  logic mplier_zero_unused;
  assign mplier_zero_unused = mplier_zero;
  assign calc_exit = (counter_q == CW'(1));
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    counter_d = counter_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_d     = mul_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && op_in != OP_NONE) begin
          load      = 1'b1;
          op_d      = op_in;
          counter_d = CW'(WIDTH);
          state_d   = (op_in == OP_DIV && div_zero) ? FIXUP : CALC;
        end
      end
      CALC: begin
        step      = 1'b1;
        counter_d = counter_q - CW'(1);
        if (calc_exit) state_d = FIXUP;
      end
      FIXUP: begin
        case (op_q)
          OP_MULT: {hi_d, lo_d} = prod;
          OP_DIV: begin
            lo_d = quot;
            hi_d = rem;
          end
          OP_MUL:  mul_d = prod[WIDTH-1:0];
          default: ;
        endcase
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIXUP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_NONE;
      counter_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      counter_q <= counter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_q     <= mul_d;
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mul_result = mul_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stall      = busy_q & (start | rd_hilo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model, randomized ops, directed corners.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAST_BUSY = 3;
`else
  localparam int LAST_BUSY = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic         rd_hilo = 1'b0;
  logic [W-1:0] hi, lo, mul_result;
  logic         busy, done, stall;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .rs_val(rs_val), .rt_val(rt_val), .rd_hilo(rd_hilo),
    .hi(hi), .lo(lo), .mul_result(mul_result),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi, lo, mr;
    int           due;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0, n_pass = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_mul = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = 32'd1;
      2: r = '1;
      3: r = 32'h8000_0000;
      4: r = 32'h7fff_ffff;
      5: r = 32'($urandom_range(0, 511)) - 32'd256;
      default: r = $urandom();
    endcase
    return r;
  endfunction

  // Reference: plain signed arithmetic on the architectural HI/LO/mul_result state.
  task automatic issue(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    logic [63:0] pv;
    int     sa, sb, lat, bl;
    logic [W-1:0] mag;
    logic   valid;
    valid    = (code == ALU_MULT) || (code == ALU_DIV) || (code == ALU_MUL);
    start    = 1'b1;
    alu_ctrl = code;
    rs_val   = a;
    rt_val   = b;
    sa  = $signed(a);
    sb  = $signed(b);
    p   = longint'(sa) * longint'(sb);
    pv  = p;
    lat = W + 2;
    if (code == ALU_MULT) begin
      m_hi = pv[63:32];
      m_lo = pv[31:0];
    end else if (code == ALU_MUL) begin
      m_mul = pv[31:0];
    end else if (code == ALU_DIV) begin
      if (b == 0) begin
        m_hi = a;
        m_lo = '1;
        lat  = 2;
      end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
        m_lo = 32'h8000_0000;
        m_hi = '0;
      end else begin
        m_lo = sa / sb;
        m_hi = sa % sb;
      end
    end
`ifdef MULDIV_EARLY_TERM_EN
    if (code == ALU_MULT || code == ALU_MUL) begin
      mag = b[W-1] ? -b : b;
      bl  = 0;
      for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
      lat = ((bl < 1) ? 1 : bl) + 2;
    end
`else
    mag = '0;
    bl  = $bits(mag);
`endif
    if (valid) begin
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.mr  = m_mul;
      e.due = cyc + lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    alu_ctrl = '0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_within_bound", 64'(k < 200), 64'd1);
  endtask

  // Monitor: every done pulse is matched against the oldest pending expectation.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done pulse with no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("mul_result", 64'(mul_result), 64'(e.mr));
      end
    end
  end

  initial begin
    int t0;
    logic [W-1:0] prev_hi, prev_lo;
    logic [3:0] code;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_mul", 64'(mul_result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Prior HI=0x11, LO=0x22, then mul must leave them alone.
    issue(ALU_DIV, 32'h451, 32'h20); wait_done();
    issue(ALU_MUL, 32'd6, 32'd7);    wait_done();

    // mult 7 * -3 with stall behaviour while busy.
    prev_hi = m_hi;
    prev_lo = m_lo;
    t0 = cyc;
    issue(ALU_MULT, 32'd7, -32'sd3);
    chk("busy_T1", 64'(busy), 64'd1);
    rd_hilo = 1'b1;
    #1 chk("stall_rd_hilo", 64'(stall), 64'd1);
    chk("hi_hold", 64'(hi), 64'(prev_hi));
    rd_hilo  = 1'b0;
    start    = 1'b1;
    alu_ctrl = ALU_DIV;
    rs_val   = 32'd9;
    rt_val   = 32'd4;
    #1 chk("stall_start", 64'(stall), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    alu_ctrl = '0;
    while (cyc < t0 + LAST_BUSY) @(negedge clk);
    chk("busy_last", 64'(busy), 64'd1);
    chk("lo_hold", 64'(lo), 64'(prev_lo));
    wait_done();
    chk("done_not_busy", 64'(busy), 64'd0);
    rd_hilo = 1'b1;
    #1 chk("stall_after_done", 64'(stall), 64'd0);
    rd_hilo = 1'b0;

    // Back-to-back divides issued in the DONE cycle, then divide by zero.
    issue(ALU_DIV, -32'sd7, 32'd2);          wait_done();
    issue(ALU_DIV, 32'h8000_0000, 32'hffff_ffff); wait_done();
    issue(ALU_DIV, 32'd5, 32'd0);            wait_done();

    issue(4'b0000, 32'd1, 32'd2);
    chk("invalid_ignored", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: code = ALU_MULT;
        3, 4:    code = ALU_DIV;
        5, 6:    code = ALU_MUL;
        default: code = ($urandom_range(0, 1) == 0) ? ALU_MFHI : ALU_MFLO;
      endcase
      issue(code, rnd_val(), rnd_val());
      if (code == ALU_MFHI || code == ALU_MFLO) chk("rand_invalid_idle", 64'(busy), 64'd0);
      else wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    issue(ALU_MULT, 32'd5, 32'd3); wait_done();

    // Reset in the middle of a mult clears everything and suppresses done.
    issue(ALU_DIV, 32'h451, 32'h20); wait_done();
    issue(ALU_MUL, 32'd6, 32'd7);    wait_done();
    t0 = cyc;
    issue(ALU_MULT, 32'h12345, 32'h777);
    while (cyc < t0 + 10) @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    m_hi  = '0;
    m_lo  = '0;
    m_mul = '0;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_mul", 64'(mul_result), 64'd0);
    reset = 1'b0;

    issue(ALU_MULT, 32'd5, 32'd3); wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
